// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_scanner
// Purpose  : Sequential binary-to-BCD (or raw hex) converter driving a
//            time-multiplexed 7-segment display with blanking and overflow.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_display_scanner #(
    parameter int BIN_W    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_cnt_w = $clog2(BIN_W);
    localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BIN_W - 1);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [BIN_W-1:0]     r_sr, w_sr_nxt;
    logic [c_bcd_w-1:0]   r_work, w_work_nxt, w_adj, w_shifted;
    logic [c_bcd_w-1:0]   r_bcd, w_bcd_nxt, w_hex_bcd;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_ovf_work, w_ovf_work_nxt;
    logic                 r_ovf, w_ovf_nxt;
    logic                 r_hex, w_hex_nxt;
    logic                 w_hex_ovf;

    generate
        if (BIN_W > c_bcd_w) begin : g_hex_trunc
            assign w_hex_bcd = bin[c_bcd_w-1:0];
            assign w_hex_ovf = |bin[BIN_W-1:c_bcd_w];
        end else begin : g_hex_ext
            assign w_hex_bcd = c_bcd_w'(bin);
            assign w_hex_ovf = 1'b0;
        end
    endgenerate

    // Double-dabble correction: digits of 5 or more get +3 before the shift
    always_comb begin
        w_adj = r_work;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_work[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
            end
        end
        w_shifted = {w_adj[c_bcd_w-2:0], r_sr[BIN_W-1]};
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sr_nxt       = r_sr;
        w_work_nxt     = r_work;
        w_cnt_nxt      = r_cnt;
        w_ovf_work_nxt = r_ovf_work;
        w_bcd_nxt      = r_bcd;
        w_ovf_nxt      = r_ovf;
        w_hex_nxt      = r_hex;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (hex_mode) begin
                        w_state_nxt = S_DONE;
                        w_bcd_nxt   = w_hex_bcd;
                        w_ovf_nxt   = w_hex_ovf;
                        w_hex_nxt   = 1'b1;
                    end else begin
                        w_state_nxt    = S_CONV;
                        w_sr_nxt       = bin;
                        w_work_nxt     = '0;
                        w_cnt_nxt      = '0;
                        w_ovf_work_nxt = 1'b0;
                    end
                end
            end
            S_CONV: begin
                w_work_nxt     = w_shifted;
                w_sr_nxt       = {r_sr[BIN_W-2:0], 1'b0};
                w_ovf_work_nxt = r_ovf_work | w_adj[c_bcd_w-1];
                w_cnt_nxt      = r_cnt + c_cnt_w'(1);
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_DONE;
                    w_bcd_nxt   = w_shifted;
                    w_ovf_nxt   = r_ovf_work | w_adj[c_bcd_w-1];
                    w_hex_nxt   = 1'b0;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_ovf_work <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_hex      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_sr_nxt;
            r_work     <= w_work_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ovf_work <= w_ovf_work_nxt;
            r_bcd      <= w_bcd_nxt;
            r_ovf      <= w_ovf_nxt;
            r_hex      <= w_hex_nxt;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d, input logic hex);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        if (!hex && d >= 4'd10) s = 7'b0000000;
        return s;
    endfunction

    logic [c_div_w-1:0] r_div;
    logic [c_idx_w-1:0] r_idx, w_idx_nxt;
    logic [DIGITS-1:0]  r_an, w_an_nxt;
    logic [6:0]         r_seg, w_seg_nxt;
    logic [3:0]         w_digit;
    logic               w_lz;

    // an/seg are registered from next-cycle values so a digit switch and a
    // result load both appear in one clean step
    always_comb begin
        w_idx_nxt = r_idx;
        if (r_div == c_div_last) begin
            w_idx_nxt = (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
        end
        w_digit  = 4'd0;
        w_lz     = 1'b1;
        w_an_nxt = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (c_idx_w'(k) == w_idx_nxt) begin
                w_digit     = w_bcd_nxt[4*k +: 4];
                w_an_nxt[k] = 1'b1;
            end
            if (k >= int'(w_idx_nxt) && w_bcd_nxt[4*k +: 4] != 4'd0) w_lz = 1'b0;
        end
        if (w_ovf_nxt)                                w_seg_nxt = 7'b1000000;
        else if (blank_lz && w_lz && w_idx_nxt != '0) w_seg_nxt = 7'b0000000;
        else                                          w_seg_nxt = seg7(w_digit, w_hex_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= '0;
            r_an  <= DIGITS'(1);
            r_seg <= 7'b0111111;
        end else begin
            r_div <= (r_div == c_div_last) ? '0 : r_div + c_div_w'(1);
            r_idx <= w_idx_nxt;
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign ovf  = r_ovf;
    assign bcd  = r_bcd;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_display_scanner
// Purpose  : Randomized self-checking bench against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

    localparam int BIN_W    = 14;
    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [BIN_W-1:0]    bin = '0;
    logic                hex_mode = 1'b0;
    logic                blank_lz = 1'b0;
    logic                busy, done, ovf;
    logic [4*DIGITS-1:0] bcd;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;

    int n_vec = 0;
    int n_err = 0;
    int n_edges = 0;
    int m_word = 0;
    bit m_ovf = 1'b0;

    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    bcd_display_scanner #(
        .BIN_W(BIN_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .busy(busy), .done(done), .ovf(ovf), .bcd(bcd),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the active digit is a pure function of it
    always @(posedge clk) begin
        if (rst) n_edges = 0;
        else     n_edges++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int i);
        int upper;
        upper = m_word >> (4 * i);
        if (m_ovf) return 7'b1000000;
        if (blank_lz && i > 0 && upper == 0) return 7'b0000000;
        return seg_tab[upper & 15];
    endfunction

    task automatic scan_check(input int ncyc);
        int idx;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            idx = (n_edges / SCAN_DIV) % DIGITS;
            check("an", 32'(an), 32'(1 << idx));
            check("seg", 32'(seg), 32'(exp_seg(idx)));
        end
    endtask

    task automatic run(input int value, input bit hex, input bit blz);
        int lat, exp_lat, w, v, p;
        bit o;
        if (hex) begin
            w = value & ((1 << (4 * DIGITS)) - 1);
            o = (value >> (4 * DIGITS)) != 0;
            exp_lat = 1;
        end else begin
            v = value % (10 ** DIGITS);
            o = value >= (10 ** DIGITS);
            w = 0;
            p = 1;
            for (int k = 0; k < DIGITS; k++) begin
                w = w | (((v / p) % 10) << (4 * k));
                p = p * 10;
            end
            exp_lat = BIN_W + 1;
        end
        @(negedge clk);
        bin = BIN_W'(value);
        hex_mode = hex;
        blank_lz = blz;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("bcd", 32'(bcd), w);
        check("ovf", 32'(ovf), 32'(o));
        m_word = w;
        m_ovf = o;
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        scan_check(DIGITS * SCAN_DIV + 2);
    endtask

    initial begin
        int ndone, val;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_an", 32'(an), 32'd1);
        check("rst_seg", 32'(seg), 32'b0111111);
        rst = 1'b0;
        scan_check(2 * DIGITS * SCAN_DIV);
        @(negedge clk);
        blank_lz = 1'b1;
        scan_check(DIGITS * SCAN_DIV + 1);

        // directed corner values
        run(255, 1'b0, 1'b0);
        run(7, 1'b0, 1'b1);
        run(1000, 1'b0, 1'b0);
        run(16383, 1'b0, 1'b1);
        run(999, 1'b0, 1'b0);
        run(0, 1'b0, 1'b1);
        run('hAF, 1'b1, 1'b0);
        run('hAF, 1'b1, 1'b1);
        run('h3ABC, 1'b1, 1'b0);
        run(40, 1'b0, 1'b1);

        // a second start during conversion must be ignored
        @(negedge clk);
        bin = BIN_W'(123);
        hex_mode = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bin = BIN_W'(456);
        hex_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("single_done", ndone, 1);
        check("ignored_bcd", 32'(bcd), 32'h123);
        m_word = 'h123;
        m_ovf = 1'b0;
        scan_check(DIGITS * SCAN_DIV);

        // reset in the middle of a conversion
        @(negedge clk);
        bin = BIN_W'(999);
        hex_mode = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_bcd", 32'(bcd), 32'd0);
        check("midrst_an", 32'(an), 32'd1);
        check("midrst_seg", 32'(seg), 32'b0111111);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        m_word = 0;
        m_ovf = 1'b0;
        scan_check(DIGITS * SCAN_DIV);

        // randomized traffic, biased toward small values to exercise blanking
        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 2))
                0:       val = $urandom_range(0, 9);
                1:       val = $urandom_range(0, 150);
                default: val = $urandom_range(0, (1 << BIN_W) - 1);
            endcase
            run(val, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
